// File: rtl/clock_button_ctrl.sv
// Digital clock control front end: debounces the mode/inc buttons, runs the
// RUN / SET_HR / SET_MIN mode machine and generates single-cycle increment pulses.
module clock_button_ctrl #(
  parameter int unsigned DEBOUNCE_TICKS = 200,
  parameter int unsigned LONG_TICKS     = 10000,
  parameter int unsigned REPEAT_TICKS   = 2000
) (
  input  logic       clk_10000Hz,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       enable,
  output logic       setting_enable,
  output logic       set_hr_or_min,
  output logic       inc_short,
  output logic [1:0] mode_state
);

  localparam logic [1:0] StRun    = 2'd0;
  localparam logic [1:0] StSetHr  = 2'd1;
  localparam logic [1:0] StSetMin = 2'd2;

  localparam logic [13:0] DbLast  = 14'(DEBOUNCE_TICKS - 1);
  localparam logic [13:0] LongCnt = 14'(LONG_TICKS);
  localparam logic [13:0] RptLast = 14'(REPEAT_TICKS - 1);

  // Bit 0 carries the mode button, bit 1 the inc button.
  logic [1:0]       btn_raw;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       level_q, level_d;
  logic [1:0]       press_q, press_d;
  logic [1:0][13:0] db_cnt_q, db_cnt_d;

  logic [1:0]  state_q, state_d;
  logic        enable_q, setting_q, hr_min_q;
  logic        inc_short_q, inc_short_d;
  logic [13:0] hold_q, hold_d;
  logic [13:0] rep_q, rep_d;
  logic        cancel_q, cancel_d;

  logic mode_press, inc_press, inc_level, in_setting, auto_fire;

  assign btn_raw = {btn_inc, btn_mode};

  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    for (int b = 0; b < 2; b++) begin
      if (sync2_q[b] != level_q[b]) begin
        if (db_cnt_q[b] == DbLast) begin
          level_d[b] = ~level_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + 14'd1;
        end
      end
    end
    press_d = level_d & ~level_q;
  end

  assign mode_press = press_q[0];
  assign inc_press  = press_q[1];
  assign inc_level  = level_q[1];
  assign in_setting = (state_q == StSetHr) || (state_q == StSetMin);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun:    if (mode_press) state_d = StSetHr;
      StSetHr:  if (mode_press) state_d = StSetMin;
      StSetMin: if (mode_press) state_d = StRun;
      default:  state_d = StRun;
    endcase
  end

  // Hold counter saturates at LONG_TICKS; from then on the repeat counter
  // wraps every REPEAT_TICKS cycles and fires each time it sits at zero.
  always_comb begin
    hold_d = '0;
    rep_d  = '0;
    if (inc_level) begin
      if (hold_q == LongCnt) begin
        hold_d = hold_q;
        rep_d  = (rep_q == RptLast) ? 14'd0 : rep_q + 14'd1;
      end else begin
        hold_d = hold_q + 14'd1;
      end
    end
    auto_fire   = inc_level && (hold_q == LongCnt) && (rep_q == 14'd0);
    // A mode change during a hold locks out pulses until inc is released.
    cancel_d    = inc_level && (cancel_q || mode_press);
    inc_short_d = in_setting && !mode_press && !cancel_q && (inc_press || auto_fire);
  end

  always_ff @(posedge clk_10000Hz or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      press_q     <= '0;
      db_cnt_q    <= '0;
      state_q     <= StRun;
      enable_q    <= 1'b1;
      setting_q   <= 1'b0;
      hr_min_q    <= 1'b0;
      inc_short_q <= 1'b0;
      hold_q      <= '0;
      rep_q       <= '0;
      cancel_q    <= 1'b0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      press_q     <= press_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      enable_q    <= (state_d == StRun);
      setting_q   <= (state_d == StSetHr) || (state_d == StSetMin);
      hr_min_q    <= (state_d == StSetMin);
      inc_short_q <= inc_short_d;
      hold_q      <= hold_d;
      rep_q       <= rep_d;
      cancel_q    <= cancel_d;
    end
  end

  assign enable         = enable_q;
  assign setting_enable = setting_q;
  assign set_hr_or_min  = hr_min_q;
  assign inc_short      = inc_short_q;
  assign mode_state     = state_q;

endmodule

// File: tb/tb_clock_button_ctrl.sv
// Bench for clock_button_ctrl: hand-derived phase table, corner-case sequences and
// randomized button activity checked every cycle against an event-timeline model.
module tb_clock_button_ctrl;

  localparam int DB = 4;
  localparam int LT = 20;
  localparam int RT = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       enable, setting_enable, set_hr_or_min, inc_short;
  logic [1:0] mode_state;

  clock_button_ctrl #(
    .DEBOUNCE_TICKS(DB),
    .LONG_TICKS    (LT),
    .REPEAT_TICKS  (RT)
  ) dut (
    .clk_10000Hz   (clk),
    .rst_n         (rst_n),
    .btn_mode      (btn_mode),
    .btn_inc       (btn_inc),
    .enable        (enable),
    .setting_enable(setting_enable),
    .set_hr_or_min (set_hr_or_min),
    .inc_short     (inc_short),
    .mode_state    (mode_state)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tick_no = 0;
  int pulse_cnt = 0;

  // Reference model: debounced levels plus timestamps of the events that matter.
  bit hist_m[$];
  bit hist_i[$];
  bit lvl_m, lvl_i;
  int run_m, run_i;
  int n_edge;
  bit mrose_prev;
  int ms;
  bit cancelled;
  int rise_i;
  bit exp_pulse;

  function automatic void model_reset();
    hist_m.delete();
    hist_i.delete();
    lvl_m = 0; lvl_i = 0; run_m = 0; run_i = 0;
    n_edge = 0; mrose_prev = 0; ms = 0; cancelled = 0; rise_i = 0; exp_pulse = 0;
  endfunction

  // A level is accepted after DB consecutive synchronized samples disagree with it.
  function automatic void deb(input bit obs, input bit lvl_in, input int run_in,
                              output bit lvl_out, output int run_out, output bit rose);
    lvl_out = lvl_in;
    run_out = 0;
    rose    = 0;
    if (obs != lvl_in) begin
      run_out = run_in + 1;
      if (run_out == DB) begin
        lvl_out = !lvl_in;
        run_out = 0;
        rose    = lvl_out;
      end
    end
  endfunction

  function automatic void model_step(input bit m, input bit i);
    bit obs_m, obs_i, rose_m, rose_i, nl;
    int nr, k;
    k = n_edge - 1 - rise_i;
    exp_pulse = (ms != 0) && lvl_i && !cancelled && !mrose_prev &&
                (k == 0 || (k >= LT && ((k - LT) % RT) == 0));
    if (!lvl_i) cancelled = 0;
    else if (mrose_prev) cancelled = 1;
    if (mrose_prev) ms = (ms + 1) % 3;
    obs_m = (hist_m.size() >= 2) ? hist_m[$-1] : 1'b0;
    obs_i = (hist_i.size() >= 2) ? hist_i[$-1] : 1'b0;
    hist_m.push_back(m);
    hist_i.push_back(i);
    if (hist_m.size() > 2) void'(hist_m.pop_front());
    if (hist_i.size() > 2) void'(hist_i.pop_front());
    deb(obs_m, lvl_m, run_m, nl, nr, rose_m);
    lvl_m = nl; run_m = nr;
    deb(obs_i, lvl_i, run_i, nl, nr, rose_i);
    lvl_i = nl; run_i = nr;
    mrose_prev = rose_m;
    if (rose_i) rise_i = n_edge;
    n_edge++;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (tick %0d): got %0h expected %0h", name, tick_no, act, exp);
    end
  endtask

  task automatic tick(input logic m, input logic i);
    logic [5:0] e;
    btn_mode = m;
    btn_inc  = i;
    @(posedge clk);
    model_step(m, i);
    @(negedge clk);
    tick_no++;
    e = {ms == 0, ms != 0, ms == 2, exp_pulse, 2'(ms)};
    check("cycle_outputs",
          32'({enable, setting_enable, set_hr_or_min, inc_short, mode_state}), 32'(e));
    if (inc_short === 1'b1) pulse_cnt++;
  endtask

  task automatic check_reset_values(input string name);
    check(name, 32'({enable, setting_enable, set_hr_or_min, inc_short, mode_state}),
          32'(6'b100000));
  endtask

  task automatic do_reset();
    btn_mode = 0;
    btn_inc  = 0;
    rst_n    = 0;
    @(negedge clk);
    @(negedge clk);
    check_reset_values("reset_values");
    rst_n = 1;
    model_reset();
  endtask

  typedef struct {
    logic       m;
    logic       i;
    int         cyc;
    logic [1:0] ms;
    logic       en;
    logic       se;
    logic       hm;
    int         pulses;
  } vec_t;

  vec_t vecs[21];

  initial begin
    int first, trans, len;
    logic [1:0] prev_ms;
    logic rm, ri;

    vecs[0]  = '{0, 0, 100, 2'd0, 1, 0, 0, 0};
    vecs[1]  = '{1, 0, 10,  2'd1, 0, 1, 0, 0};
    vecs[2]  = '{0, 0, 10,  2'd1, 0, 1, 0, 0};
    vecs[3]  = '{1, 0, 10,  2'd2, 0, 1, 1, 0};
    vecs[4]  = '{0, 0, 10,  2'd2, 0, 1, 1, 0};
    vecs[5]  = '{0, 1, 10,  2'd2, 0, 1, 1, 1};
    vecs[6]  = '{0, 0, 10,  2'd2, 0, 1, 1, 0};
    vecs[7]  = '{1, 0, 10,  2'd0, 1, 0, 0, 0};
    vecs[8]  = '{0, 0, 10,  2'd0, 1, 0, 0, 0};
    vecs[9]  = '{0, 1, 40,  2'd0, 1, 0, 0, 0};
    vecs[10] = '{0, 0, 10,  2'd0, 1, 0, 0, 0};
    vecs[11] = '{1, 0, 10,  2'd1, 0, 1, 0, 0};
    vecs[12] = '{0, 0, 10,  2'd1, 0, 1, 0, 0};
    vecs[13] = '{0, 1, 45,  2'd1, 0, 1, 0, 5};
    vecs[14] = '{0, 0, 15,  2'd1, 0, 1, 0, 1};
    vecs[15] = '{0, 1, 30,  2'd1, 0, 1, 0, 2};
    vecs[16] = '{1, 1, 10,  2'd2, 0, 1, 1, 1};
    vecs[17] = '{0, 1, 30,  2'd2, 0, 1, 1, 0};
    vecs[18] = '{0, 0, 10,  2'd2, 0, 1, 1, 0};
    vecs[19] = '{0, 1, 10,  2'd2, 0, 1, 1, 1};
    vecs[20] = '{0, 0, 10,  2'd2, 0, 1, 1, 0};

    model_reset();
    do_reset();
    for (int v = 0; v < 21; v++) begin
      pulse_cnt = 0;
      for (int c = 0; c < vecs[v].cyc; c++) tick(vecs[v].m, vecs[v].i);
      check($sformatf("phase%0d_mode", v),
            32'({enable, setting_enable, set_hr_or_min, mode_state}),
            32'({vecs[v].en, vecs[v].se, vecs[v].hm, vecs[v].ms}));
      check($sformatf("phase%0d_pulses", v), 32'(pulse_cnt), 32'(vecs[v].pulses));
    end

    // Short glitches must be filtered; the stable press lands 7 ticks in.
    do_reset();
    for (int c = 0; c < 5; c++) tick(0, 0);
    for (int c = 0; c < 10; c++) begin
      tick(1, 0);
      tick(0, 0);
    end
    check("glitch_no_change", 32'(mode_state), 32'd0);
    first = 0;
    trans = 0;
    prev_ms = mode_state;
    for (int c = 1; c <= 10; c++) begin
      tick(1, 0);
      if (mode_state !== prev_ms) trans++;
      if (mode_state === 2'd1 && first == 0) first = c;
      prev_ms = mode_state;
    end
    check("debounce_latency", 32'(first), 32'd7);
    check("debounce_single_transition", 32'(trans), 32'd1);

    // Randomized activity, biased toward long inc holds in setting modes.
    do_reset();
    for (int s = 0; s < 200; s++) begin
      rm  = ($urandom_range(0, 3) == 0);
      ri  = $urandom_range(0, 1) == 1;
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                        : int'($urandom_range(1, 8));
      for (int c = 0; c < len; c++) tick(rm, ri);
    end

    // Asynchronous reset in the middle of an inc hold, buttons kept pressed.
    do_reset();
    for (int c = 0; c < 10; c++) tick(1, 0);
    for (int c = 0; c < 10; c++) tick(0, 0);
    for (int c = 0; c < 15; c++) tick(1, 1);
    #2 rst_n = 0;
    #1 check_reset_values("async_reset_mid_hold");
    @(negedge clk);
    rst_n = 1;
    model_reset();
    pulse_cnt = 0;
    for (int c = 0; c < 10; c++) tick(1, 1);
    check("held_through_reset_press", 32'(mode_state), 32'd1);
    check("held_through_reset_no_inc", 32'(pulse_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_button_ctrl.md
# clock_button_ctrl

- Upstream control stage of the digital clock.
- Debounces the two raw push-buttons and runs the mode state machine (RUN / SET_HR / SET_MIN).
- Produces the `enable`, `setting_enable`, `set_hr_or_min` and `inc_short` controls that drive the time counter.
- Guarantees `inc_short` is a single-cycle pulse; the counter increments once for every cycle this pulse is high.

## Interface
Parameters:
- `DEBOUNCE_TICKS`, 200: consecutive stable cycles before a button level is accepted (20 ms at 10 kHz); legal range 1..16383.
- `LONG_TICKS`, 10000: hold duration after which `inc` auto-repeat begins (1 s); legal range 2..16383.
- `REPEAT_TICKS`, 2000: auto-repeat period while `inc` is held (0.2 s); legal range 1..16383.

Ports:
- `clk_10000Hz` input 1: sole clock, rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `btn_mode` input 1: raw mode button, active-high, asynchronous, bouncy.
- `btn_inc` input 1: raw increment button, active-high, asynchronous, bouncy.
- `enable` output 1: counter run enable; 1 only in RUN.
- `setting_enable` output 1: 1 in SET_HR or SET_MIN.
- `set_hr_or_min` output 1: 0 = hours, 1 = minutes; meaningful only while `setting_enable`=1.
- `inc_short` output 1: one-cycle increment pulse; never high in RUN.
- `mode_state` output 2: current mode, RUN=0, SET_HR=1, SET_MIN=2.

## Operation
**Reset (`rst_n`=0).** All flops clear:
- Synchronizers, debounced levels, counters, state = RUN.
- `enable`=1, `setting_enable`=0, `set_hr_or_min`=0, `inc_short`=0, `mode_state`=0.

**Synchronize and debounce (per button).**
- Each button passes through a 2-flop synchronizer.
- A 14-bit debounce counter clears whenever the synchronized value equals the debounced level. Otherwise it increments.
- When the counter reaches `DEBOUNCE_TICKS`, the debounced level flips and the counter clears.
- A press edge is a debounced 0->1 transition, registered one cycle later.

**Mode FSM** (state encoding 2'd3 unreachable; if entered, the next state is RUN):
- A mode press edge advances RUN -> SET_HR -> SET_MIN -> RUN.
- Outputs are registered and decoded from the state: RUN gives 1/0/0, SET_HR gives 0/1/0, SET_MIN gives 0/1/1 for `enable`/`setting_enable`/`set_hr_or_min`.

**Increment logic.**
- It is active only in SET_HR or SET_MIN. In RUN, inc press edges and holds are ignored and `inc_short` stays 0.
- An inc press edge produces one `inc_short` pulse.
- A 14-bit hold counter runs while the debounced inc level is 1. When it reaches `LONG_TICKS`, one pulse is issued.
- After that, a repeat counter issues a pulse every `REPEAT_TICKS` cycles until release.
- Release (debounced level 0) clears the hold and repeat counters immediately; no pulse is issued on release.

**Simultaneous events and special cases.**
- Mode press edge and inc pulse in the same cycle: the mode change wins and `inc_short` is suppressed that cycle.
- Any mode change while inc is held cancels auto-repeat. No further pulses occur until inc is released and pressed again.
- A button held through reset release is seen as a fresh press once its debounce completes.

## Timing
- Raw-to-debounced latency: 2 sync cycles plus `DEBOUNCE_TICKS` cycles.
- Glitches shorter than `DEBOUNCE_TICKS` cycles after synchronization produce no change.
- Let T be the cycle in which the debounced inc level first reads 1 (in a SET state):
  - `inc_short` is high at T+1 only.
  - Repeat pulses occur at T+`LONG_TICKS`+1, then every `REPEAT_TICKS` cycles thereafter.
- The mode press edge changes `mode_state` and all three mode outputs together in the cycle after the debounced mode level rises.
- `inc_short` width is exactly 1 cycle. Two pulses are never adjacent unless `REPEAT_TICKS`=1.
- Asserting `rst_n` mid-hold or mid-debounce forces reset values immediately, asynchronously.

## Test plan
Bench parameters: `DEBOUNCE_TICKS`=4, `LONG_TICKS`=20, `REPEAT_TICKS`=5.
- **Reset:** `rst_n` low, then high with buttons at 0 -> `enable`=1, `setting_enable`=0, `set_hr_or_min`=0, `inc_short`=0, `mode_state`=0, held for 100 cycles.
- **Debounce:** `btn_mode` toggled 1-cycle high/low 10 times, then held high 10 cycles -> exactly one transition RUN->SET_HR, about 7 cycles after the stable high begins.
- **Mode cycle:** three clean `btn_mode` presses -> `mode_state` 1, 2, 0. `set_hr_or_min` is 0, 1, 0. `enable` returns to 1 only after the third press.
- **Single increment:** in SET_MIN, `btn_inc` held high 10 cycles then released -> exactly one 1-cycle `inc_short` pulse.
- **Auto-repeat:** in SET_HR, `btn_inc` held 40 debounced cycles -> pulses at T+1, T+21, T+26, T+31, T+36; none after release.
- **Special cases:**
  - In RUN, `btn_inc` held 40 cycles -> `inc_short` never high.
  - In SET_HR with inc held, a mode press -> no pulse that cycle and no further repeats until re-press.
